// File: rtl/serial_pkg.sv
// serial_pkg: shared definitions for the serial receive path.
//   - parity mode encodings (PAR_NONE / PAR_ODD / PAR_EVEN)
//   - receiver state enum
//   - calc_div: rounded clock divider producing the oversample tick
`timescale 1ns/1ps
package serial_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // ST_ prefix keeps the names clear of the PARITY parameter in the top.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_PUSH   = 3'd5
  } rx_state_e;

  // round(clock_freq / (baud * oversample)), never below 1.
  function automatic int calc_div(input int clock_freq, input int baud,
                                  input int oversample);
    int den;
    int q;
    den = baud * oversample;
    q   = (clock_freq + den / 2) / den;
    return (q < 1) ? 1 : q;
  endfunction

endpackage

// File: rtl/serial_fifo.sv
// serial_fifo: show-ahead synchronous FIFO.
//   clk100     in   clock
//   reset      in   asynchronous active-low reset, empties the FIFO
//   push       in   write push_data when not full (or when popping while full)
//   push_data  in   WIDTH-bit entry
//   full       out  DEPTH entries held
//   pop        in   remove head when not empty
//   pop_data   out  head entry, valid whenever empty=0
//   empty      out  no entries held
// Pointers carry one extra bit so full and empty are distinguishable.
`timescale 1ns/1ps
module serial_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic             clk100,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_pop;
  logic             do_push;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a
  // simultaneous push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk100 or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/serial_rx_fifo.sv
// serial_rx_fifo: oversampling UART receiver feeding a small FIFO.
//   clk100        in   system clock
//   reset         in   asynchronous active-low reset
//   rx            in   asynchronous serial line, idle high
//   rx_data       out  head data, LSB = first bit received
//   rx_frame_err  out  head entry: a stop bit sampled 0
//   rx_parity_err out  head entry: parity mismatch
//   rx_break      out  head entry: frame error with all data/parity votes 0
//   rx_valid      out  FIFO non-empty
//   rx_ready      in   pop head
//   overrun       out  sticky: frame dropped on full FIFO
//   clr_overrun   in   synchronous clear of overrun (a same-cycle drop wins)
//   busy          out  frame in progress
//   rx_state      out  receiver state (rx_state_e encoding) for observation
//
// Handshake: the head entry transfers on every clock edge where
// rx_valid && rx_ready; rx_valid never depends on rx_ready, head fields are
// stable while rx_valid is high and not popped, rx_ready is ignored when empty.
`timescale 1ns/1ps
module serial_rx_fifo
  import serial_pkg::*;
#(
  parameter int CLOCK_FREQ = 100000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk100,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_break,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 overrun,
  input  logic                 clr_overrun,
  output logic                 busy,
  output logic [2:0]           rx_state
);

  localparam int DIV   = calc_div(CLOCK_FREQ, BAUD, OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int S_W   = $clog2(OVERSAMPLE);
  localparam int B_W   = $clog2(DATA_BITS + 1);
  localparam int E_W   = DATA_BITS + 3;

  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(DIV - 1);
  localparam logic [S_W-1:0]   S_V0   = S_W'(OVERSAMPLE/2 - 1);
  localparam logic [S_W-1:0]   S_V1   = S_W'(OVERSAMPLE/2);
  localparam logic [S_W-1:0]   S_DEC  = S_W'(OVERSAMPLE/2 + 1);
  localparam logic [S_W-1:0]   S_LAST = S_W'(OVERSAMPLE - 1);
  localparam logic [B_W-1:0]   B_LAST = B_W'(DATA_BITS);

  // ---------------------------------------------------------------- sync
  logic       sync1, sync2, rs, rs_prev;
  logic [2:0] settle;

  // settle holds off edge detection until the synchroniser and rs_prev
  // carry real line samples, so a line that is low at reset release is
  // not mistaken for a start bit.
  always_ff @(posedge clk100 or negedge reset) begin
    if (!reset) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      rs_prev <= 1'b1;
      settle  <= '0;
    end else begin
      sync1   <= rx;
      sync2   <= sync1;
      rs_prev <= sync2;
      settle  <= {settle[1:0], 1'b1};
    end
  end
  assign rs = sync2;

  // ---------------------------------------------------------------- tick
  rx_state_e        state;
  logic [DIV_W-1:0] tick_cnt;
  logic             tick;
  logic             start_edge;

  assign tick       = (tick_cnt == '0);
  assign start_edge = (state == ST_IDLE) && settle[2] && rs_prev && !rs;

  // Reloading on the start edge phase-aligns sample ticks to the frame.
  always_ff @(posedge clk100 or negedge reset) begin
    if (!reset)                  tick_cnt <= DIV_RELOAD;
    else if (start_edge || tick) tick_cnt <= DIV_RELOAD;
    else                         tick_cnt <= tick_cnt - DIV_W'(1);
  end

  // ---------------------------------------------------------------- FSM
  logic [S_W-1:0]       s;
  logic                 v0, v1;
  logic [B_W-1:0]       bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 all_zero;
  logic                 ferr;
  logic                 stop_second;
  logic [E_W-1:0]       entry;
  logic                 vote;
  logic                 par_x;
  logic                 perr_calc;
  logic                 ferr_final;
  logic                 last_stop;

  assign vote       = (v0 & v1) | (v0 & rs) | (v1 & rs);
  assign par_x      = (^shreg) ^ par_bit;
  assign perr_calc  = (PARITY == PAR_ODD)  ? ~par_x :
                      (PARITY == PAR_EVEN) ?  par_x : 1'b0;
  assign ferr_final = ferr | ~vote;
  assign last_stop  = (STOP_BITS == 1) || stop_second;

  always_ff @(posedge clk100 or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      s           <= '0;
      v0          <= 1'b1;
      v1          <= 1'b1;
      bit_cnt     <= '0;
      shreg       <= '0;
      par_bit     <= 1'b0;
      all_zero    <= 1'b1;
      ferr        <= 1'b0;
      stop_second <= 1'b0;
      entry       <= '0;
    end else begin
      if (state == ST_IDLE) begin
        if (start_edge) begin
          state       <= ST_START;
          s           <= '0;
          bit_cnt     <= '0;
          all_zero    <= 1'b1;
          ferr        <= 1'b0;
          stop_second <= 1'b0;
          par_bit     <= 1'b0;
        end
      end else if (state == ST_PUSH) begin
        // entry is written to the FIFO during this single cycle
        state <= ST_IDLE;
      end else if (tick) begin
        s <= (s == S_LAST) ? '0 : s + S_W'(1);
        if (s == S_V0) v0 <= rs;
        if (s == S_V1) v1 <= rs;

        if (s == S_DEC) begin
          if (state == ST_START) begin
            if (vote) state <= ST_IDLE;  // glitch, not a start bit
          end else if (state == ST_DATA) begin
            shreg    <= {vote, shreg[DATA_BITS-1:1]};
            all_zero <= all_zero & ~vote;
            bit_cnt  <= bit_cnt + B_W'(1);
          end else if (state == ST_PARITY) begin
            par_bit  <= vote;
            all_zero <= all_zero & ~vote;
          end else if (state == ST_STOP) begin
            if (last_stop) begin
              entry <= {ferr_final & all_zero, perr_calc, ferr_final, shreg};
              state <= ST_PUSH;
            end else begin
              ferr <= ferr_final;
            end
          end
        end

        if (s == S_LAST) begin
          if (state == ST_START) begin
            state <= ST_DATA;
          end else if (state == ST_DATA) begin
            if (bit_cnt == B_LAST) state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else if (state == ST_PARITY) begin
            state <= ST_STOP;
          end else if (state == ST_STOP) begin
            stop_second <= 1'b1;  // only reached for the first of two stop bits
          end
        end
      end
    end
  end

  assign busy     = (state != ST_IDLE);
  assign rx_state = state;

  // ---------------------------------------------------------------- FIFO
  logic           push;
  logic           fifo_full;
  logic           fifo_empty;
  logic [E_W-1:0] head;

  assign push = (state == ST_PUSH);

  serial_fifo #(
    .WIDTH (E_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk100    (clk100),
    .reset     (reset),
    .push      (push),
    .push_data (entry),
    .full      (fifo_full),
    .pop       (rx_ready),
    .pop_data  (head),
    .empty     (fifo_empty)
  );

  assign rx_valid      = !fifo_empty;
  assign rx_data       = fifo_empty ? '0   : head[DATA_BITS-1:0];
  assign rx_frame_err  = fifo_empty ? 1'b0 : head[DATA_BITS];
  assign rx_parity_err = fifo_empty ? 1'b0 : head[DATA_BITS+1];
  assign rx_break      = fifo_empty ? 1'b0 : head[DATA_BITS+2];

  // A full FIFO is never empty, so a drop only happens without a pop.
  always_ff @(posedge clk100 or negedge reset) begin
    if (!reset)                             overrun <= 1'b0;
    else if (push && fifo_full && !rx_ready) overrun <= 1'b1;
    else if (clr_overrun)                   overrun <= 1'b0;
  end

endmodule

// File: tb/tb_serial_rx_fifo.sv
// tb_serial_rx_fifo: directed bench with expected-queue scoreboards.
// DUT A is 8N1 with a 4-deep FIFO; DUT B is 7E1. Both run at DIV=4 so a
// bit lasts 64 clocks.
`timescale 1ns/1ps
module tb_serial_rx_fifo;
  import serial_pkg::*;

  localparam int CF  = 100000000;
  localparam int BD  = 1562500;
  localparam int OS  = 16;
  localparam int DIV = 4;
  localparam int BIT = DIV * OS;

  // ------------------------------------------------ clock / reset
  logic clk100 = 1'b0;
  logic reset  = 1'b0;
  always #5 clk100 = ~clk100;

  // ------------------------------------------------ DUT A (8N1)
  logic       rx_a = 1'b1, ready_a = 1'b1, clr_a = 1'b0;
  logic [7:0] data_a;
  logic       ferr_a, perr_a, brk_a, valid_a, ovr_a, busy_a;
  logic [2:0] state_a;

  serial_rx_fifo #(
    .CLOCK_FREQ(CF), .BAUD(BD), .OVERSAMPLE(OS), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_dut_a (
    .clk100(clk100), .reset(reset), .rx(rx_a), .rx_data(data_a),
    .rx_frame_err(ferr_a), .rx_parity_err(perr_a), .rx_break(brk_a),
    .rx_valid(valid_a), .rx_ready(ready_a), .overrun(ovr_a),
    .clr_overrun(clr_a), .busy(busy_a), .rx_state(state_a)
  );

  // ------------------------------------------------ DUT B (7E1)
  logic       rx_b = 1'b1, ready_b = 1'b1, clr_b = 1'b0;
  logic [6:0] data_b;
  logic       ferr_b, perr_b, brk_b, valid_b, ovr_b, busy_b;
  logic [2:0] state_b;

  serial_rx_fifo #(
    .CLOCK_FREQ(CF), .BAUD(BD), .OVERSAMPLE(OS), .DATA_BITS(7),
    .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_dut_b (
    .clk100(clk100), .reset(reset), .rx(rx_b), .rx_data(data_b),
    .rx_frame_err(ferr_b), .rx_parity_err(perr_b), .rx_break(brk_b),
    .rx_valid(valid_b), .rx_ready(ready_b), .overrun(ovr_b),
    .clr_overrun(clr_b), .busy(busy_b), .rx_state(state_b)
  );

  // ------------------------------------------------ scoreboard
  // entry = {break, parity_err, frame_err, data[8:0]}
  logic [11:0] exp_a_q[$];
  logic [11:0] exp_b_q[$];
  int checks   = 0;
  int failures = 0;
  logic found;

  function automatic logic [11:0] mk(input logic brk, input logic perr,
                                     input logic ferr, input logic [8:0] d);
    return {brk, perr, ferr, d};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic mon_compare(input string name, input logic [11:0] got, input int which);
    logic [11:0] exp;
    checks++;
    if ((which == 0 && exp_a_q.size() == 0) || (which == 1 && exp_b_q.size() == 0)) begin
      failures++;
      $display("FAIL %s unexpected entry actual=0x%03h expected=none", name, got);
    end else begin
      exp = (which == 0) ? exp_a_q.pop_front() : exp_b_q.pop_front();
      if (got !== exp) begin
        failures++;
        $display("FAIL %s actual=0x%03h expected=0x%03h", name, got, exp);
      end
    end
  endtask

  // monitors: a pop happens at the next rising edge
  always @(negedge clk100) begin
    if (reset && valid_a && ready_a)
      mon_compare("pop_a", {brk_a, perr_a, ferr_a, 1'b0, data_a}, 0);
    if (reset && valid_b && ready_b)
      mon_compare("pop_b", {brk_b, perr_b, ferr_b, 2'b00, data_b}, 1);
  end

  // ------------------------------------------------ driver tasks
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk100);
    #1;
  endtask

  task automatic set_line(input int line, input logic v);
    if (line == 0) rx_a = v;
    else           rx_b = v;
  endtask

  task automatic send_frame(input int line, input logic [8:0] d, input int nbits,
                            input logic has_par, input logic par, input logic stop);
    set_line(line, 1'b0);
    wait_clk(BIT);
    for (int i = 0; i < nbits; i++) begin
      set_line(line, d[i]);
      wait_clk(BIT);
    end
    if (has_par) begin
      set_line(line, par);
      wait_clk(BIT);
    end
    set_line(line, stop);
    wait_clk(BIT);
    set_line(line, 1'b1);
    wait_clk(BIT);
  endtask

  // ------------------------------------------------ watchdog
  initial begin
    #800000;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  // ------------------------------------------------ stimulus
  initial begin
    int n;

    // reset state
    wait_clk(3);
    check("rst_valid", valid_a, 0);
    check("rst_data", data_a, 0);
    check("rst_flags", {brk_a, perr_a, ferr_a}, 0);
    check("rst_overrun", ovr_a, 0);
    check("rst_busy", busy_a, 0);
    reset = 1'b1;
    wait_clk(4);
    check("rel_valid", valid_a, 0);

    // 8N1 basic frames
    exp_a_q.push_back(mk(0, 0, 0, 9'h055));
    send_frame(0, 9'h055, 8, 0, 0, 1);
    exp_a_q.push_back(mk(0, 0, 0, 9'h0A3));
    send_frame(0, 9'h0A3, 8, 0, 0, 1);

    // 7E1: 0x41 has two ones, so even parity bit is 0
    exp_b_q.push_back(mk(0, 0, 0, 9'h041));
    send_frame(1, 9'h041, 7, 1, 0, 1);
    exp_b_q.push_back(mk(0, 1, 0, 9'h041));
    send_frame(1, 9'h041, 7, 1, 1, 1);

    // framing error
    exp_a_q.push_back(mk(0, 0, 1, 9'h07E));
    send_frame(0, 9'h07E, 8, 0, 0, 0);

    // break: line low for 20 bit times gives exactly one entry
    exp_a_q.push_back(mk(1, 0, 1, 9'h000));
    set_line(0, 1'b0);
    wait_clk(20 * BIT);
    set_line(0, 1'b1);
    wait_clk(2 * BIT);

    // glitch of 3 ticks: start rejected, nothing pushed
    set_line(0, 1'b0);
    wait_clk(3 * DIV);
    set_line(0, 1'b1);
    check("glitch_busy", busy_a, 1);
    n = 3 * DIV;
    while (busy_a && n < (OS/2 + 2) * DIV + 10) begin
      wait_clk(1);
      n++;
    end
    check("glitch_idle", busy_a, 0);
    wait_clk(2 * BIT);
    check("glitch_nopush", valid_a, 0);

    // FIFO fill and overrun
    ready_a = 1'b0;
    exp_a_q.push_back(mk(0, 0, 0, 9'h011));
    exp_a_q.push_back(mk(0, 0, 0, 9'h022));
    exp_a_q.push_back(mk(0, 0, 0, 9'h033));
    exp_a_q.push_back(mk(0, 0, 0, 9'h044));
    send_frame(0, 9'h011, 8, 0, 0, 1);
    send_frame(0, 9'h022, 8, 0, 0, 1);
    send_frame(0, 9'h033, 8, 0, 0, 1);
    send_frame(0, 9'h044, 8, 0, 0, 1);
    check("full_no_overrun", ovr_a, 0);
    send_frame(0, 9'h055, 8, 0, 0, 1);  // dropped
    check("overrun_set", ovr_a, 1);
    check("full_valid", valid_a, 1);
    check("full_head", data_a, 8'h11);
    clr_a = 1'b1;
    wait_clk(1);
    clr_a = 1'b0;
    check("overrun_clr", ovr_a, 0);

    // frame 6 completes in the same cycle as a pop
    exp_a_q.push_back(mk(0, 0, 0, 9'h066));
    found = 1'b0;
    fork
      send_frame(0, 9'h066, 8, 0, 0, 1);
      begin
        for (int i = 0; i < 20 * BIT && !found; i++) begin
          @(posedge clk100);
          #1;
          if (state_a == ST_PUSH) found = 1'b1;
        end
        if (found) begin
          ready_a = 1'b1;
          wait_clk(1);
          ready_a = 1'b0;
        end
      end
    join
    check("push_seen", found, 1);
    check("pushpop_no_overrun", ovr_a, 0);
    ready_a = 1'b1;
    wait_clk(10);
    check("drain_a", exp_a_q.size(), 0);

    // reset mid-frame: a held entry is flushed and the frame abandoned
    ready_a = 1'b0;
    send_frame(0, 9'h033, 8, 0, 0, 1);
    check("held_before_rst", valid_a, 1);
    set_line(0, 1'b0);               // start bit
    wait_clk(BIT);
    wait_clk(3 * BIT + BIT / 2);     // into data bit 3 (all zeros)
    reset = 1'b0;
    wait_clk(2);
    check("rst_mid_valid", valid_a, 0);
    check("rst_mid_busy", busy_a, 0);
    wait_clk(BIT - 2);
    reset = 1'b1;                    // line still low
    wait_clk(4);
    check("rel_low_busy", busy_a, 0);
    wait_clk(BIT * 7 / 2 - 4);
    set_line(0, 1'b1);
    wait_clk(2 * BIT);
    check("rel_no_entry", valid_a, 0);
    check("rel_idle", busy_a, 0);
    ready_a = 1'b1;
    exp_a_q.push_back(mk(0, 0, 0, 9'h05A));
    send_frame(0, 9'h05A, 8, 0, 0, 1);

    wait_clk(2 * BIT);
    check("final_queue_a", exp_a_q.size(), 0);
    check("final_queue_b", exp_b_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
